nf_reg_wb_ctrl: RTL and testbench

Write-back controller that owns the register-file write port (wa3/wd3/we3). It merges single-cycle ALU results with variable-latency load returns from the load/store unit. Load returns are buffered in a small FIFO and drained into free write-port slots. A starvation counter forces a pipeline stall when loads wait too long, and stale buffered loads are killed by younger ALU writes to the same register.

---
 rtl/nf_reg_wb_ctrl_pkg.sv | 19 +
 rtl/nf_reg_wb_ctrl_if.sv | 40 ++++
 rtl/nf_reg_wb_ctrl_fifo.sv | 77 +++++++
 rtl/nf_reg_wb_ctrl.sv | 165 ++++++++++++++++
 tb/tb_nf_reg_wb_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/nf_reg_wb_ctrl_pkg.sv
// nf_wb_pkg: shared types and constants for the write-back controller.
//   wb_req_t   : one register-file write request (destination + data)
//   wb_state_e : starvation FSM state (RUN = normal arbitration, STALL = drain loads)
package nf_wb_pkg;

    localparam int NF_XLEN    = 32;
    localparam int NF_RADDR_W = 5;

    typedef struct packed {
        logic [NF_RADDR_W-1:0] wa;
        logic [NF_XLEN-1:0]    wd;
    } wb_req_t;

    typedef enum logic {
        WB_RUN   = 1'b0,
        WB_STALL = 1'b1
    } wb_state_e;

endpackage

// File: rtl/nf_reg_wb_ctrl_if.sv
// nf_reg_wb_ctrl_if: bundle between the core pipeline / LSU and the
// write-back controller.
//   alu_we/alu_wa/alu_wd : ALU result offer, held off by alu_stall
//   lsu_req/lsu_wa/lsu_wd: load return offer, accepted by lsu_ack
//   wa3/wd3/we3          : register-file write port (registered)
//   alu_stall, pend_busy : pipeline hold and "loads still buffered" status
//   wb_state             : starvation FSM state, for observation only
//
// Handshakes: a load return transfers on every cycle where lsu_req and
// lsu_ack are both 1; when lsu_ack is 0 the LSU holds the same return and
// offers it again. An ALU result transfers on every cycle where alu_we=1 and
// alu_stall=0; while alu_stall=1 the pipeline holds and re-offers it.
interface nf_reg_wb_ctrl_if;
    import nf_wb_pkg::*;

    logic                  alu_we;
    logic [NF_RADDR_W-1:0] alu_wa;
    logic [NF_XLEN-1:0]    alu_wd;
    logic                  lsu_req;
    logic [NF_RADDR_W-1:0] lsu_wa;
    logic [NF_XLEN-1:0]    lsu_wd;
    logic                  lsu_ack;
    logic                  alu_stall;
    logic [NF_RADDR_W-1:0] wa3;
    logic [NF_XLEN-1:0]    wd3;
    logic                  we3;
    logic                  pend_busy;
    wb_state_e             wb_state;

    modport slave (
        input  alu_we, alu_wa, alu_wd, lsu_req, lsu_wa, lsu_wd,
        output lsu_ack, alu_stall, wa3, wd3, we3, pend_busy, wb_state
    );

    modport master (
        output alu_we, alu_wa, alu_wd, lsu_req, lsu_wa, lsu_wd,
        input  lsu_ack, alu_stall, wa3, wd3, we3, pend_busy, wb_state
    );

endinterface

// File: rtl/nf_reg_wb_ctrl_fifo.sv
// nf_wb_fifo: circular buffer of pending load returns. Each entry carries a
// live bit; a kill request clears the live bit of every entry whose
// destination matches, so the entry still drains but is never written.
//   push/push_data/push_live : enqueue at the tail (push_live=0 enters dead)
//   pop                      : dequeue the head
//   kill/kill_wa             : invalidate all stored entries targeting kill_wa
//   head/head_live           : head entry and whether it must still be written
//   count/full               : occupancy
//   any_live                 : at least one live entry is stored
module nf_wb_fifo
    import nf_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  wb_req_t                 push_data,
    input  logic                    push_live,
    input  logic                    pop,
    input  logic                    kill,
    input  logic [NF_RADDR_W-1:0]   kill_wa,
    output wb_req_t                 head,
    output logic                    head_live,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    any_live
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_req_t          mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    // Pointers are PW bits wide and DEPTH is a power of two, so they wrap
    // naturally. Kill is applied first, then pop, then push: a push into the
    // slot being popped (full + pop) must win over the pop's clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill && vld[i] && (mem[i].wa == kill_wa)) begin
                    vld[i] <= 1'b0;
                end
            end
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + 1'b1;
            end
            if (push) begin
                vld[wr_ptr] <= push_live;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Payload storage needs no reset; the live bits qualify it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head      = mem[rd_ptr];
    assign head_live = vld[rd_ptr];
    assign full      = (count == CW'(DEPTH));
    assign any_live  = |vld;

endmodule

// File: rtl/nf_reg_wb_ctrl.sv
// nf_reg_wb_ctrl: owns the register-file write port. Each cycle one writer is
// selected (ALU, then buffered load, then a direct load bypass) and written
// one cycle later on wa3/wd3/we3. Loads that lose arbitration are buffered;
// if the buffer sits full while the ALU keeps winning for STARVE_LIM cycles,
// the pipeline is stalled until the buffer has drained.
//   clk, rst : core clock, asynchronous active-high reset
//   bus      : slave side of nf_reg_wb_ctrl_if (see interface for signals)
module nf_reg_wb_ctrl
    import nf_wb_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    nf_reg_wb_ctrl_if.slave   bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIM) + 1;

    wb_state_e         state, state_next;
    logic [SW-1:0]     starve_cnt, starve_cnt_next;
    logic              alu_stall;

    wb_req_t           head;
    logic              head_live;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic              full;
    logic              empty;
    logic              any_live;

    logic              alu_take;
    logic              pop;
    logic              bypass;
    logic              push;
    logic              push_live;
    logic              starve_cond;

    logic                  sel_we;
    logic [NF_RADDR_W-1:0] sel_wa;
    logic [NF_XLEN-1:0]    sel_wd;
    logic                  we3_q;
    logic [NF_RADDR_W-1:0] wa3_q;
    logic [NF_XLEN-1:0]    wd3_q;

    // ------------------------------------------------------------------
    // Slot arbitration. An ALU write to x0 is dropped and does not occupy
    // the slot, so a buffered load may use it instead.
    // ------------------------------------------------------------------
    assign empty    = (count == '0);
    assign alu_take = bus.alu_we && !alu_stall && (bus.alu_wa != '0);
    assign pop      = !alu_take && !empty;
    assign bypass   = !alu_take && empty && bus.lsu_req;
    assign push     = bus.lsu_req && (bus.lsu_wa != '0) && !bypass && (!full || pop);
    // The ALU result is younger than a load arriving in the same cycle, so a
    // same-destination load enters the buffer already dead.
    assign push_live   = !(alu_take && (bus.lsu_wa == bus.alu_wa));
    assign count_next  = count + CW'(push) - CW'(pop);
    assign starve_cond = full && alu_take;

    assign bus.lsu_ack = bus.lsu_req && (!full || pop || bypass);

    always_comb begin
        sel_we = 1'b0;
        sel_wa = '0;
        sel_wd = '0;
        if (alu_take) begin
            sel_we = 1'b1;
            sel_wa = bus.alu_wa;
            sel_wd = bus.alu_wd;
        end else if (pop) begin
            // A killed head still consumes the slot, just without a write.
            if (head_live) begin
                sel_we = 1'b1;
                sel_wa = head.wa;
                sel_wd = head.wd;
            end
        end else if (bypass && (bus.lsu_wa != '0)) begin
            sel_we = 1'b1;
            sel_wa = bus.lsu_wa;
            sel_wd = bus.lsu_wd;
        end
    end

    nf_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ('{wa: bus.lsu_wa, wd: bus.lsu_wd}),
        .push_live (push_live),
        .pop       (pop),
        .kill      (alu_take),
        .kill_wa   (bus.alu_wa),
        .head      (head),
        .head_live (head_live),
        .count     (count),
        .full      (full),
        .any_live  (any_live)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we3_q <= 1'b0;
            wa3_q <= '0;
            wd3_q <= '0;
        end else begin
            we3_q <= sel_we;
            wa3_q <= sel_wa;
            wd3_q <= sel_wd;
        end
    end

    // ------------------------------------------------------------------
    // Starvation FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WB_RUN;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_cnt_next;
        end
    end

    always_comb begin
        state_next      = state;
        starve_cnt_next = '0;
        case (state)
            WB_RUN: begin
                if (starve_cond) begin
                    if (starve_cnt == SW'(STARVE_LIM - 1)) begin
                        state_next = WB_STALL;
                    end else begin
                        starve_cnt_next = starve_cnt + 1'b1;
                    end
                end
            end
            WB_STALL: begin
                // Leave once the drain has made room for more than one new
                // load, or the buffer is empty.
                if ((count_next == '0) || (count_next < CW'(DEPTH - 1))) begin
                    state_next = WB_RUN;
                end
            end
            default: state_next = WB_RUN;
        endcase
    end

    always_comb begin
        alu_stall = (state == WB_STALL);
    end

    assign bus.alu_stall = alu_stall;
    assign bus.we3       = we3_q;
    assign bus.wa3       = wa3_q;
    assign bus.wd3       = wd3_q;
    assign bus.pend_busy = any_live;
    assign bus.wb_state  = state;

endmodule

// File: tb/tb_nf_reg_wb_ctrl.sv
// Directed bench for nf_reg_wb_ctrl (DEPTH=2, STARVE_LIM=4).
module tb_nf_reg_wb_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    logic ack_s;

    // {wa, wd} of every register-file write the bench expects, in order
    logic [36:0] exp_q[$];

    nf_reg_wb_ctrl_if bus();

    nf_reg_wb_ctrl #(
        .DEPTH      (2),
        .STARVE_LIM (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Every write seen on the port must be the next expected one.
    always @(negedge clk) begin
        if (bus.we3 === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_we3", 32'(bus.we3), 32'd0);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("wr_wa3", 32'(bus.wa3), 32'(e[36:32]));
                check("wr_wd3", bus.wd3, e[31:0]);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic expect_wr(input logic [4:0] wa, input logic [31:0] wd);
        exp_q.push_back({wa, wd});
    endtask

    // Called just after a rising edge: present one cycle of inputs, capture
    // lsu_ack mid-cycle, return just after the next rising edge with inputs idle.
    task automatic cyc(input logic aw, input logic [4:0] awa, input logic [31:0] awd,
                       input logic lr, input logic [4:0] lwa, input logic [31:0] lwd);
        bus.alu_we  = aw;
        bus.alu_wa  = awa;
        bus.alu_wd  = awd;
        bus.lsu_req = lr;
        bus.lsu_wa  = lwa;
        bus.lsu_wd  = lwd;
        #2;
        ack_s = bus.lsu_ack;
        @(posedge clk);
        #1;
        bus.alu_we  = 1'b0;
        bus.lsu_req = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        bus.alu_we  = 1'b1;
        bus.alu_wa  = 5'd5;
        bus.alu_wd  = 32'hDEADBEEF;
        bus.lsu_req = 1'b0;
        bus.lsu_wa  = 5'd0;
        bus.lsu_wd  = 32'd0;

        // Outputs held at zero while reset is high, even with ALU activity.
        repeat (2) @(posedge clk);
        #1;
        check("rst_we3", 32'(bus.we3), 32'd0);
        check("rst_wa3", 32'(bus.wa3), 32'd0);
        check("rst_wd3", bus.wd3, 32'd0);
        check("rst_stall", 32'(bus.alu_stall), 32'd0);
        check("rst_pend", 32'(bus.pend_busy), 32'd0);
        bus.alu_we = 1'b0;
        rst = 1'b0;
        idle();

        // ALU write, one cycle latency
        expect_wr(5'd5, 32'hDEADBEEF);
        cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        check("alu_we3", 32'(bus.we3), 32'd1);
        idle();
        check("alu_idle_we3", 32'(bus.we3), 32'd0);

        // Load bypass with empty FIFO
        expect_wr(5'd7, 32'h11);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h11);
        check("byp_ack", 32'(ack_s), 32'd1);
        check("byp_we3", 32'(bus.we3), 32'd1);
        check("byp_pend", 32'(bus.pend_busy), 32'd0);

        // Buffered load to x9 killed by a younger ALU write to x9
        expect_wr(5'd3, 32'h33);
        cyc(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h99);
        check("kill_ack", 32'(ack_s), 32'd1);
        check("kill_pend_set", 32'(bus.pend_busy), 32'd1);
        expect_wr(5'd9, 32'h22);
        cyc(1'b1, 5'd9, 32'h22, 1'b0, 5'd0, 32'd0);
        check("kill_pend_clr", 32'(bus.pend_busy), 32'd0);
        idle();
        check("kill_dead_pop_we3", 32'(bus.we3), 32'd0);
        idle();

        // Starvation: fill the FIFO, keep the ALU winning
        expect_wr(5'd1, 32'h101);
        cyc(1'b1, 5'd1, 32'h101, 1'b1, 5'd10, 32'hA0);
        check("fill_ack0", 32'(ack_s), 32'd1);
        expect_wr(5'd2, 32'h102);
        cyc(1'b1, 5'd2, 32'h102, 1'b1, 5'd11, 32'hB0);
        check("fill_ack1", 32'(ack_s), 32'd1);
        expect_wr(5'd12, 32'h112);
        cyc(1'b1, 5'd12, 32'h112, 1'b1, 5'd20, 32'hC0);
        check("full_ack", 32'(ack_s), 32'd0);
        check("stall_c1", 32'(bus.alu_stall), 32'd0);
        for (int i = 1; i < 4; i++) begin
            expect_wr(5'(12 + i), 32'h112 + 32'(i));
            cyc(1'b1, 5'(12 + i), 32'h112 + 32'(i), 1'b0, 5'd0, 32'd0);
            check($sformatf("stall_c%0d", i + 1), 32'(bus.alu_stall), (i == 3) ? 32'd1 : 32'd0);
        end
        // ALU offer ignored during stall; loads drain in order
        expect_wr(5'd10, 32'hA0);
        cyc(1'b1, 5'd25, 32'h555, 1'b0, 5'd0, 32'd0);
        check("drain0_we3", 32'(bus.we3), 32'd1);
        check("drain0_stall", 32'(bus.alu_stall), 32'd1);
        expect_wr(5'd11, 32'hB0);
        cyc(1'b1, 5'd25, 32'h555, 1'b0, 5'd0, 32'd0);
        check("drain1_we3", 32'(bus.we3), 32'd1);
        check("drain1_stall", 32'(bus.alu_stall), 32'd0);
        expect_wr(5'd25, 32'h555);
        cyc(1'b1, 5'd25, 32'h555, 1'b0, 5'd0, 32'd0);
        check("post_stall_we3", 32'(bus.we3), 32'd1);
        check("post_stall_pend", 32'(bus.pend_busy), 32'd0);

        // x0 writes discarded, load still acked, nothing buffered
        cyc(1'b1, 5'd0, 32'h77, 1'b1, 5'd0, 32'h88);
        check("x0_ack", 32'(ack_s), 32'd1);
        check("x0_we3", 32'(bus.we3), 32'd0);
        check("x0_pend", 32'(bus.pend_busy), 32'd0);
        // A load now bypasses only if the FIFO is truly empty.
        expect_wr(5'd4, 32'h44);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44);
        check("x0_after_we3", 32'(bus.we3), 32'd1);

        // Reset with two loads buffered
        expect_wr(5'd6, 32'h606);
        cyc(1'b1, 5'd6, 32'h606, 1'b1, 5'd13, 32'hD0);
        expect_wr(5'd8, 32'h808);
        cyc(1'b1, 5'd8, 32'h808, 1'b1, 5'd14, 32'hE0);
        check("pre_rst_pend", 32'(bus.pend_busy), 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_we3", 32'(bus.we3), 32'd0);
        check("mid_rst_pend", 32'(bus.pend_busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle();
            check($sformatf("post_rst_we3_%0d", i), 32'(bus.we3), 32'd0);
        end
        check("post_rst_pend", 32'(bus.pend_busy), 32'd0);
        expect_wr(5'd15, 32'hF0);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd15, 32'hF0);
        check("post_rst_ack", 32'(ack_s), 32'd1);
        check("post_rst_load_we3", 32'(bus.we3), 32'd1);
        idle();
        idle();

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
